fetch_ctrl: RTL

//  Sequences the instruction memory: owns the program counter, drives imem_addr,
//  and buffers fetched words in a small queue that feeds decode through a

---
 rtl/fetch_pkg.sv | 29 ++
 rtl/fetch_fifo.sv | 78 +++++++
 rtl/fetch_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch block.
//   fetch_state_t : sequencer states (IDLE, RUN, DRAIN, HALTED)
//   fetch_entry_t : one queued fetch, the instruction word plus its address
//   HALT_INSTR    : instruction word that ends a program
package fetch_pkg;

  localparam int ADDR_WIDTH = 10;
  localparam int DATA_WIDTH = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  localparam logic [DATA_WIDTH-1:0] HALT_INSTR = 9'h1FF;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] pc;
  } fetch_entry_t;

  // True when a word is the program-ending instruction.
  function automatic logic is_halt(input logic [DATA_WIDTH-1:0] word);
    return (word == HALT_INSTR);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: QDEPTH-entry synchronous queue of fetch_entry_t.
// Entries shift toward slot 0, so the head is always a flop (registered head).
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   push        write push_data at the tail this cycle
//   pop         drop the head this cycle (caller guarantees non-empty)
//   flush       empty the queue; overrides push and pop
//   push_data   entry to enqueue
//   head        current head entry
//   head_valid  queue non-empty (registered)
//   count       number of occupied entries
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fetch_entry_t                 push_data,
  output fetch_entry_t                 head,
  output logic                         head_valid,
  output logic [$clog2(QDEPTH+1)-1:0]  count
);

  localparam int CW = $clog2(QDEPTH + 1);

  fetch_entry_t          ent_q [QDEPTH];
  fetch_entry_t          ent_d [QDEPTH];
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_d;
  logic [CW-1:0]         wr_idx;
  logic                  valid_q;

  // Next queue contents: shift on pop, then write the tail slot on push.
  always_comb begin
    ent_d   = ent_q;
    count_d = count_q;
    wr_idx  = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < QDEPTH - 1; i++) begin
          ent_d[i] = ent_q[i+1];
        end
        // After the shift the free tail slot sits one position lower.
        wr_idx = count_q - CW'(1);
      end else begin
        wr_idx = count_q;
      end
      for (int i = 0; i < QDEPTH; i++) begin
        ent_d[i] = (push && (wr_idx == CW'(i))) ? push_data : ent_d[i];
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Queue storage, occupancy and registered head-valid flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q   <= '{default: '0};
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
      valid_q <= (count_d != '0);
    end
  end

  assign head       = ent_q[0];
  assign head_valid = valid_q;
  assign count      = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer. Owns the PC, addresses instr_mem,
// queues fetched words and hands them to decode over valid/ready.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   start                  begin fetching at START_ADDR (IDLE/HALTED only)
//   imem_addr/imem_instr   instruction memory address out, same-cycle data in
//   out_valid/out_instr/out_pc/out_ready   decode handshake
//   br_taken/br_target     redirect pulse and target
//   done                   program halted (level)
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                    QDEPTH     = 2,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_instr,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc,
  input  logic                  out_ready,
  input  logic                  br_taken,
  input  logic [ADDR_WIDTH-1:0] br_target,
  output logic                  done
);

  localparam int CW = $clog2(QDEPTH + 1);

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  done_q, done_d;
  logic                  push, pop, flush, enq_ok;
  fetch_entry_t          head;
  logic                  head_valid;
  logic [CW-1:0]         count;

  assign pop    = head_valid && out_ready;
  // A same-cycle pop frees a slot, which keeps throughput at one per cycle.
  assign enq_ok = (count < CW'(QDEPTH)) || pop;

  // Next state, PC and queue controls; a branch outranks fetch and halt.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    done_d  = done_q;
    push    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          state_d = RUN;
          pc_d    = START_ADDR;
          done_d  = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      RUN: begin
        if (br_taken) begin
          flush = 1'b1;
          pc_d  = br_target;
        end else if (enq_ok) begin
          push    = 1'b1;
          pc_d    = pc_q + ADDR_WIDTH'(1);
          state_d = is_halt(imem_instr) ? DRAIN : RUN;
        end else begin
          pc_d = pc_q;
        end
      end
      DRAIN: begin
        if (br_taken) begin
          flush   = 1'b1;
          pc_d    = br_target;
          state_d = RUN;
        end else if (pop && is_halt(head.instr)) begin
          state_d = HALTED;
          done_d  = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, program counter and halt flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= START_ADDR;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
    end
  end

  fetch_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .push_data  ('{instr: imem_instr, pc: pc_q}),
    .head       (head),
    .head_valid (head_valid),
    .count      (count)
  );

  assign imem_addr = pc_q;
  assign out_valid = head_valid;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  assign done      = done_q;

endmodule
